ahbl_mem_arbiter: RTL

Two-master AHB-Lite arbiter that shares one single-port AHB-Lite memory slave (the on-chip ROM/RAM) between two bus masters, e.g. the CPU data port (M0) and the CPU instruction port or a DMA (M1). Neither master has a grant input, so the arbiter accepts a losing master's address phase into a holding register, stalls that master with HREADY low, and replays the transfer to the slave once the bus is free. Uncontested transfers pass through with zero added wait states.

---
 rtl/ahbl_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ahbl_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-port memory slave.
// A losing master's address phase is held in a pend register and replayed once the slave is free.
module ahbl_mem_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic        S_HSEL,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic [2:0]  S_HSIZE,
    output logic        S_HWRITE,
    output logic [31:0] S_HWDATA,
    output logic        S_HREADY,
    input  logic        S_HREADYOUT,
    input  logic [31:0] S_HRDATA
);

    typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

    logic [1:0][31:0] m_haddr, paddr_q, paddr_d;
    logic [1:0][2:0]  m_hsize, psize_q, psize_d;
    logic [1:0]       m_hwrite, m_htrans1, pwrite_q, pwrite_d;
    logic [1:0]       pend_q, pend_d, new_req, req, m_hready, win;
    owner_e           owner_q, owner_d;
    logic             last_q, last_d;
    logic             gnt_valid, gnt;
    logic             unused_htrans0;

    assign m_haddr   = {M1_HADDR, M0_HADDR};
    assign m_hsize   = {M1_HSIZE, M0_HSIZE};
    assign m_hwrite  = {M1_HWRITE, M0_HWRITE};
    assign m_htrans1 = {M1_HTRANS[1], M0_HTRANS[1]};
    assign unused_htrans0 = M0_HTRANS[0] ^ M1_HTRANS[0];

    assign m_hready[0] = !pend_q[0] && ((owner_q != OwnM0) || S_HREADYOUT);
    assign m_hready[1] = !pend_q[1] && ((owner_q != OwnM1) || S_HREADYOUT);
    assign M0_HREADY   = m_hready[0];
    assign M1_HREADY   = m_hready[1];
    assign S_HREADY    = S_HREADYOUT;

    // Gating with HRESETn keeps the slave idle while reset is held.
    assign new_req   = m_hready & m_htrans1 & {2{HRESETn}};
    assign req       = pend_q | new_req;
    assign gnt_valid = |req;
    assign gnt       = (&req) ? (RR ? ~last_q : 1'b0) : req[1];
    assign win       = (gnt_valid && S_HREADYOUT) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        S_HSEL   = 1'b0;
        S_HTRANS = 2'b00;
        S_HADDR  = 32'h0;
        S_HSIZE  = 3'h0;
        S_HWRITE = 1'b0;
        if (gnt_valid) begin
            S_HSEL   = 1'b1;
            S_HTRANS = 2'b10;
            if (pend_q[gnt]) begin
                S_HADDR  = paddr_q[gnt];
                S_HSIZE  = psize_q[gnt];
                S_HWRITE = pwrite_q[gnt];
            end else begin
                S_HADDR  = m_haddr[gnt];
                S_HSIZE  = m_hsize[gnt];
                S_HWRITE = m_hwrite[gnt];
            end
        end
    end

    always_comb begin
        S_HWDATA  = 32'h0;
        M0_HRDATA = 32'h0;
        M1_HRDATA = 32'h0;
        unique case (owner_q)
            OwnM0: begin
                S_HWDATA  = M0_HWDATA;
                M0_HRDATA = S_HRDATA;
            end
            OwnM1: begin
                S_HWDATA  = M1_HWDATA;
                M1_HRDATA = S_HRDATA;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        pend_d   = pend_q;
        paddr_d  = paddr_q;
        psize_d  = psize_q;
        pwrite_d = pwrite_q;
        if (S_HREADYOUT) begin
            if (gnt_valid) begin
                owner_d = gnt ? OwnM1 : OwnM0;
                last_d  = gnt;
            end else begin
                owner_d = OwnNone;
            end
        end
        // A new request is captured even during slave wait states.
        for (int i = 0; i < 2; i++) begin
            if (win[i]) begin
                pend_d[i] = 1'b0;
            end else if (new_req[i]) begin
                pend_d[i]   = 1'b1;
                paddr_d[i]  = m_haddr[i];
                psize_d[i]  = m_hsize[i];
                pwrite_d[i] = m_hwrite[i];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q  <= OwnNone;
            last_q   <= 1'b1;
            pend_q   <= 2'b00;
            paddr_q  <= '0;
            psize_q  <= '0;
            pwrite_q <= '0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            paddr_q  <= paddr_d;
            psize_q  <= psize_d;
            pwrite_q <= pwrite_d;
        end
    end

endmodule
